// File: rtl/video_timing_pkg.sv
// Timing constants and shared types for the raster generator.
// Defaults describe a 1080p60 frame.
package video_timing_pkg;

  localparam int unsigned VT_FRAME_WIDTH   = 2200;
  localparam int unsigned VT_FRAME_HEIGHT  = 1125;
  localparam int unsigned VT_SCREEN_WIDTH  = 1920;
  localparam int unsigned VT_SCREEN_HEIGHT = 1080;
  localparam int unsigned VT_H_SYNC_START  = 2008;
  localparam int unsigned VT_H_SYNC_END    = 2052;
  localparam int unsigned VT_V_SYNC_START  = 1084;
  localparam int unsigned VT_V_SYNC_END    = 1089;
  localparam int unsigned VT_BIT_WIDTH     = 12;
  localparam int unsigned VT_BIT_HEIGHT    = 11;
  localparam int unsigned VT_PIPE_LATENCY  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with async active-low clear.
// Depth 0 degenerates to a straight wire.
module sync_delay_line #(
  parameter int unsigned W     = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign o_q = i_d;
    end else begin : g_pipe
      logic [W-1:0] r_sr [DEPTH];

      // shift the sample one stage per clock
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < int'(DEPTH); i++)
            r_sr[i] <= '0;
        end else begin
          r_sr[0] <= i_d;
          for (int i = 1; i < int'(DEPTH); i++)
            r_sr[i] <= r_sr[i-1];
        end
      end

      assign o_q = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Raster scanner, sync/de alignment to the pixel pipeline
// and periodic image_change scheduling in vertical blank.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH   = VT_FRAME_WIDTH,
  parameter int unsigned FRAME_HEIGHT  = VT_FRAME_HEIGHT,
  parameter int unsigned SCREEN_WIDTH  = VT_SCREEN_WIDTH,
  parameter int unsigned SCREEN_HEIGHT = VT_SCREEN_HEIGHT,
  parameter int unsigned H_SYNC_START  = VT_H_SYNC_START,
  parameter int unsigned H_SYNC_END    = VT_H_SYNC_END,
  parameter int unsigned V_SYNC_START  = VT_V_SYNC_START,
  parameter int unsigned V_SYNC_END    = VT_V_SYNC_END,
  parameter logic        HSYNC_POL     = 1'b1,
  parameter logic        VSYNC_POL     = 1'b1,
  parameter int unsigned BIT_WIDTH     = VT_BIT_WIDTH,
  parameter int unsigned BIT_HEIGHT    = VT_BIT_HEIGHT,
  parameter int unsigned PIPE_LATENCY  = VT_PIPE_LATENCY
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  enable,
  input  logic                  auto_start,
  input  logic [7:0]            frame_hold,
  input  logic [23:0]           rgb_in,
  output logic [BIT_WIDTH-1:0]  cx,
  output logic [BIT_HEIGHT-1:0] cy,
  output logic                  image_change,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [23:0]           rgb_out,
  output logic [31:0]           frame_count
);

  localparam logic [BIT_WIDTH-1:0] L_CX_LAST =
    BIT_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [BIT_WIDTH-1:0] L_SW =
    BIT_WIDTH'(SCREEN_WIDTH);
  localparam logic [BIT_WIDTH-1:0] L_HSS =
    BIT_WIDTH'(H_SYNC_START);
  localparam logic [BIT_WIDTH-1:0] L_HSE =
    BIT_WIDTH'(H_SYNC_END);
  localparam logic [BIT_HEIGHT-1:0] L_CY_LAST =
    BIT_HEIGHT'(FRAME_HEIGHT - 1);
  localparam logic [BIT_HEIGHT-1:0] L_SH =
    BIT_HEIGHT'(SCREEN_HEIGHT);
  localparam logic [BIT_HEIGHT-1:0] L_SH_LAST =
    BIT_HEIGHT'(SCREEN_HEIGHT - 1);
  localparam logic [BIT_HEIGHT-1:0] L_VSS =
    BIT_HEIGHT'(V_SYNC_START);
  localparam logic [BIT_HEIGHT-1:0] L_VSE =
    BIT_HEIGHT'(V_SYNC_END);

  state_t r_state;
  state_t w_state_nxt;

  logic [BIT_WIDTH-1:0]  r_cx;
  logic [BIT_HEIGHT-1:0] r_cy;
  logic [31:0]           r_frame_cnt;
  logic [7:0]            r_div;
  logic                  r_img_chg;
  logic                  r_de;
  logic                  r_hs;
  logic                  r_vs;
  logic [23:0]           r_rgb;

  logic       w_run;
  logic       w_line_end;
  logic       w_frame_end;
  logic       w_bound;
  logic       w_de_raw;
  logic       w_hs_raw;
  logic       w_vs_raw;
  logic [2:0] w_dl;

  assign w_run       = (r_state == RUN);
  assign w_line_end  = (r_cx == L_CX_LAST);
  assign w_frame_end = w_line_end && (r_cy == L_CY_LAST);
  // last clock before the first blank line is presented
  assign w_bound     = w_run && w_line_end &&
                       (r_cy == L_SH_LAST);

  // state register
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) r_state <= IDLE;
    else                r_state <= w_state_nxt;
  end

  // next state: start on enable, stop only at frame end
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (enable) w_state_nxt = RUN;
      RUN:  if (w_frame_end && !enable) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // raster counters and completed-frame count
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_cx        <= '0;
      r_cy        <= '0;
      r_frame_cnt <= '0;
    end else if (w_run) begin
      if (w_line_end) begin
        r_cx <= '0;
        if (w_frame_end) begin
          r_cy        <= '0;
          r_frame_cnt <= r_frame_cnt + 32'd1;
        end else begin
          r_cy <= r_cy + 1'b1;
        end
      end else begin
        r_cx <= r_cx + 1'b1;
      end
    end else begin
      r_cx <= '0;
      r_cy <= '0;
    end
  end

  // image swap divider, fires as (0, SCREEN_HEIGHT) appears
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_div     <= '0;
      r_img_chg <= 1'b0;
    end else begin
      r_img_chg <= 1'b0;
      if (w_bound) begin
        if (auto_start && (frame_hold != 8'd0)) begin
          if (r_div >= frame_hold - 8'd1) begin
            r_img_chg <= 1'b1;
            r_div     <= '0;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end else begin
          r_div <= '0;
        end
      end
    end
  end

  assign w_de_raw = w_run && (r_cx < L_SW) && (r_cy < L_SH);
  assign w_hs_raw = w_run && (r_cx >= L_HSS) && (r_cx < L_HSE);
  assign w_vs_raw = w_run && (r_cy >= L_VSS) && (r_cy < L_VSE);

  sync_delay_line #(
    .W     (3),
    .DEPTH (PIPE_LATENCY)
  ) u_dly (
    .i_clk   (s_axi_aclk),
    .i_rst_n (s_axi_aresetn),
    .i_d     ({w_de_raw, w_hs_raw, w_vs_raw}),
    .o_q     (w_dl)
  );

  // output stage aligned with the returned pixel
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_de  <= 1'b0;
      r_hs  <= ~HSYNC_POL;
      r_vs  <= ~VSYNC_POL;
      r_rgb <= '0;
    end else begin
      r_de  <= w_dl[2];
      r_hs  <= w_dl[1] ? HSYNC_POL : ~HSYNC_POL;
      r_vs  <= w_dl[0] ? VSYNC_POL : ~VSYNC_POL;
      r_rgb <= w_dl[2] ? rgb_in : 24'd0;
    end
  end

  assign cx           = r_cx;
  assign cy           = r_cy;
  assign image_change = r_img_chg;
  assign hsync        = r_hs;
  assign vsync        = r_vs;
  assign de           = r_de;
  assign rgb_out      = r_rgb;
  assign frame_count  = r_frame_cnt;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a shrunk raster
// (24x14 total, 16x10 active) with a 2-clock pixel source.
module tb_video_timing_gen;

  localparam int FW  = 24;
  localparam int FH  = 14;
  localparam int SW  = 16;
  localparam int SH  = 10;
  localparam int HSS = 18;
  localparam int HSE = 21;
  localparam int VSS = 11;
  localparam int VSE = 13;
  localparam int FRM = FW * FH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        auto_s = 1'b0;
  logic [7:0]  fh = 8'd0;
  logic [23:0] rgb_in;
  logic [11:0] cx;
  logic [10:0] cy;
  logic        image_change;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [23:0] rgb_out;
  logic [31:0] frame_count;

  logic [23:0] p1, p2;

  int n_tot = 0;
  int n_bad = 0;

  // bench model state
  bit mrun;
  int mx, my, mfc, mdiv;
  bit mic;
  bit hr [4];
  int hx [4];
  int hy [4];

  always #5 clk = ~clk;

  video_timing_gen #(
    .FRAME_WIDTH   (FW),
    .FRAME_HEIGHT  (FH),
    .SCREEN_WIDTH  (SW),
    .SCREEN_HEIGHT (SH),
    .H_SYNC_START  (HSS),
    .H_SYNC_END    (HSE),
    .V_SYNC_START  (VSS),
    .V_SYNC_END    (VSE),
    .HSYNC_POL     (1'b1),
    .VSYNC_POL     (1'b1),
    .BIT_WIDTH     (12),
    .BIT_HEIGHT    (11),
    .PIPE_LATENCY  (2)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .enable        (en),
    .auto_start    (auto_s),
    .frame_hold    (fh),
    .rgb_in        (rgb_in),
    .cx            (cx),
    .cy            (cy),
    .image_change  (image_change),
    .hsync         (hsync),
    .vsync         (vsync),
    .de            (de),
    .rgb_out       (rgb_out),
    .frame_count   (frame_count)
  );

  // image controller stand-in: pixel {cx,cy} two clocks later
  always @(posedge clk) begin
    p1 <= {1'b0, cx, cy};
    p2 <= p1;
  end
  assign rgb_in = p2;

  function automatic logic [23:0] pix(input int x, input int y);
    return {1'b0, 12'(x), 11'(y)};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mrun = 0; mx = 0; my = 0; mfc = 0; mdiv = 0; mic = 0;
    for (int i = 0; i < 4; i++) begin
      hr[i] = 0; hx[i] = 0; hy[i] = 0;
    end
  endtask

  // one clock: advance the model, then check every output
  task automatic tick();
    bit pr;
    int px, py;
    bit e_de, e_hs, e_vs;
    pr = mrun; px = mx; py = my;
    @(posedge clk);
    mic = 0;
    if (pr && px == FW-1 && py == SH-1) begin
      if (auto_s && fh != 0) begin
        if (mdiv >= int'(fh) - 1) begin
          mic = 1; mdiv = 0;
        end else mdiv++;
      end else mdiv = 0;
    end
    if (!pr) begin
      if (en) mrun = 1;
      mx = 0; my = 0;
    end else if (px == FW-1) begin
      mx = 0;
      if (py == FH-1) begin
        my = 0; mfc++;
        if (!en) mrun = 0;
      end else my = py + 1;
    end else mx = px + 1;
    for (int i = 3; i > 0; i--) begin
      hr[i] = hr[i-1]; hx[i] = hx[i-1]; hy[i] = hy[i-1];
    end
    hr[0] = mrun; hx[0] = mx; hy[0] = my;
    #1;
    e_de = hr[3] && hx[3] < SW && hy[3] < SH;
    e_hs = hr[3] && hx[3] >= HSS && hx[3] < HSE;
    e_vs = hr[3] && hy[3] >= VSS && hy[3] < VSE;
    chk("cx", cx, mx);
    chk("cy", cy, my);
    chk("fc", frame_count, mfc);
    chk("ic", image_change, mic);
    chk("de", de, e_de);
    chk("hs", hsync, e_hs);
    chk("vs", vsync, e_vs);
    chk("rgb", rgb_out, e_de ? pix(hx[3], hy[3]) : 24'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cx"}, cx, 0);
    chk({tag, "_cy"}, cy, 0);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_hs"}, hsync, 0);
    chk({tag, "_vs"}, vsync, 0);
    chk({tag, "_rgb"}, rgb_out, 0);
    chk({tag, "_ic"}, image_change, 0);
    chk({tag, "_fc"}, frame_count, 0);
  endtask

  initial begin
    int de_rise, de_fall, hs_rise, hs_cnt, vs_cnt;
    int npulse, x0, nstop, lim;
    int pfc [3];
    int pcx [3];
    int pcy [3];
    bit prev_de;

    model_reset();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst0");
    #20 rst_n = 1'b1;

    // held in IDLE while enable low
    for (int i = 0; i < 5; i++) tick();
    chk("idle_cx", cx, 0);

    // ten frames, image change every 3
    en = 1'b1; auto_s = 1'b1; fh = 8'd3;
    de_rise = -1; de_fall = -1; hs_rise = -1;
    hs_cnt = 0; vs_cnt = 0; npulse = 0; prev_de = 0;
    for (int n = 0; n < 10 * FRM; n++) begin
      tick();
      if (n < FW) begin
        if (de && de_rise < 0) de_rise = n;
        if (!de && prev_de && de_fall < 0) de_fall = n;
        if (hsync && hs_rise < 0) hs_rise = n;
        if (hsync) hs_cnt++;
      end
      prev_de = de;
      if (vsync) vs_cnt++;
      if (image_change) begin
        if (npulse < 3) begin
          pfc[npulse] = frame_count;
          pcx[npulse] = cx;
          pcy[npulse] = cy;
        end
        npulse++;
      end
    end
    chk("de_rise", de_rise, 3);
    chk("de_fall", de_fall, SW + 3);
    chk("hs_rise", hs_rise, HSS + 3);
    chk("hs_len", hs_cnt, HSE - HSS);
    chk("vs_cycles", vs_cnt, 10 * (VSE - VSS) * FW);
    chk("last_cx", cx, FW - 1);
    chk("last_cy", cy, FH - 1);
    chk("fc_pre", frame_count, 9);
    tick();
    chk("wrap_cx", cx, 0);
    chk("wrap_cy", cy, 0);
    chk("fc_10", frame_count, 10);
    chk("pulse_n", npulse, 3);
    for (int i = 0; i < 3; i++) begin
      chk("pulse_fc", pfc[i], 3 * i + 2);
      chk("pulse_cx", pcx[i], 0);
      chk("pulse_cy", pcy[i], SH);
    end

    // auto_start off, then frame_hold zero: no pulses
    auto_s = 1'b0;
    npulse = 0;
    for (int n = 0; n < 3 * FRM; n++) begin
      tick();
      if (image_change) npulse++;
    end
    chk("no_auto", npulse, 0);
    auto_s = 1'b1; fh = 8'd0;
    npulse = 0;
    for (int n = 0; n < 3 * FRM; n++) begin
      tick();
      if (image_change) npulse++;
    end
    chk("no_hold", npulse, 0);

    // hold=1: pulse every frame
    fh = 8'd1;
    npulse = 0;
    for (int n = 0; n < 2 * FRM; n++) begin
      tick();
      if (image_change) npulse++;
    end
    chk("hold1", npulse, 2);

    // drop enable mid-frame at line 5
    lim = 0;
    while (cy != 11'd5 && lim < 2 * FRM) begin
      tick(); lim++;
    end
    chk("reach_cy5", cy, 5);
    x0 = cx;
    en = 1'b0;
    nstop = (FH - 1 - 5) * FW + (FW - x0);
    for (int n = 0; n < nstop; n++) tick();
    chk("stop_cx", cx, 0);
    chk("stop_cy", cy, 0);
    chk("stop_fc", frame_count, 10 + 3 + 3 + 2 + 1);
    for (int n = 0; n < 30; n++) tick();
    chk("idle_cx2", cx, 0);
    chk("idle_de", de, 0);
    chk("idle_hs", hsync, 0);
    chk("idle_vs", vsync, 0);

    // restart, then async reset mid-line at line 7
    en = 1'b1;
    lim = 0;
    while (!(cy == 11'd7 && cx == 12'd4) && lim < 2 * FRM) begin
      tick(); lim++;
    end
    chk("reach_cy7", cy, 7);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_mid");
    model_reset();
    en = 1'b0;
    #13 rst_n = 1'b1;
    for (int n = 0; n < 10; n++) tick();
    chk("post_rst_cx", cx, 0);
    en = 1'b1;
    for (int n = 0; n < 6; n++) tick();
    chk("restart_cx", cx, 5);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
